// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side burst master for a same-clock FIFO; streams words out with an end-of-burst marker.
// Latency: read request in cycle N, word visible on o_m_valid from cycle N+2 (1 word/cycle sustained).
// Backpressure: i_m_ready low holds the 2-entry output buffer; reads throttle so in-flight + buffered <= 2.
// Optional: define FIFO_BURST_READER_STATS_EN to add o_word_cnt / o_burst_cnt transfer counters.
module fifo_burst_reader #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 32,
  localparam int COUNT_W   = $clog2(FIFO_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_fifo_rd_en,
  input  logic [WIDTH-1:0]   i_fifo_rd_data,
  input  logic               i_fifo_rd_valid,
  input  logic               i_fifo_e_flag,
  input  logic [COUNT_W-1:0] i_fifo_count,
  output logic [WIDTH-1:0]   o_m_data,
  output logic               o_m_valid,
  output logic               o_m_last,
  input  logic               i_m_ready,
`ifdef FIFO_BURST_READER_STATS_EN
  output logic [31:0]        o_word_cnt,
  output logic [15:0]        o_burst_cnt,
`endif
  output logic               o_busy
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BEAT_W-1:0] BURST_FULL = BEAT_W'(BURST_LEN);
  // Timer value on which a partial burst is launched; unused when TIMEOUT is 0.
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // FSM and burst bookkeeping
  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [BEAT_W-1:0] target_q, target_d;

  // One read can be in flight; its last tag travels with it into the buffer.
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  // Two-entry in-order output buffer; entry 0 is the head driving the stream outputs.
  logic [WIDTH-1:0]  ent_dat_q [2];
  logic [WIDTH-1:0]  ent_dat_d [2];
  logic [1:0]        ent_last_q, ent_last_d;
  logic [1:0]        occ_q, occ_d;

  logic              pop;
  logic              push;
  logic              push_last;
  logic              room;
  logic              tag_pending;
  logic              full_ready;
  logic              partial_ready;
  logic              rd_en;
  logic              issue_last;
  logic              retag;
  logic              retag_inflight;
  logic              retag_ent0;
  logic              retag_ent1;

  assign pop  = (occ_q != 2'd0) & i_m_ready;
  assign push = inflight_q & i_fifo_rd_valid;

  // Words owed to the buffer after this cycle must stay within its two entries.
  assign room = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  // A last-tagged word is still on its way out; the burst cannot end until it is popped.
  assign tag_pending = (inflight_q & inflight_last_q) | (|ent_last_q);

  assign full_ready    = (int'(i_fifo_count) >= BURST_LEN);
  assign partial_ready = (TIMEOUT != 0) && (timer_q == TMR_LAST) && !i_fifo_e_flag;

  // Early close: the newest issued word takes the last tag. A head word leaving this
  // cycle is already gone downstream, so it cannot be tagged.
  assign retag_inflight = retag & inflight_q;
  assign retag_ent1     = retag & !inflight_q & (occ_q == 2'd2);
  assign retag_ent0     = retag & !inflight_q & (occ_q == 2'd1) & !pop;
  assign push_last      = inflight_last_q | retag_inflight;

  // Next-state, read issue and burst-close decisions.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    beats_d         = beats_q;
    target_d        = target_q;
    rd_en           = 1'b0;
    issue_last      = 1'b0;
    retag           = 1'b0;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        beats_d = '0;
        timer_d = i_fifo_e_flag ? '0 : (timer_q + 1'b1);
        if (full_ready) begin
          state_d  = ST_BURST;
          target_d = BURST_FULL;
          timer_d  = '0;
        end else if (partial_ready) begin
          // Count is below BURST_LEN on this branch, so it fits the beat counter.
          state_d  = ST_BURST;
          target_d = BEAT_W'(i_fifo_count);
          timer_d  = '0;
        end
      end
      ST_BURST: begin
        timer_d = '0;
        if (i_fifo_e_flag) begin
          if (beats_q < target_q) begin
            target_d = beats_q;
            retag    = 1'b1;
          end
        end else if ((beats_q < target_q) && room && !i_rst) begin
          rd_en      = 1'b1;
          beats_d    = beats_q + 1'b1;
          issue_last = ((beats_q + 1'b1) == target_q);
        end
        if (pop && ent_last_q[0]) begin
          state_d = ST_IDLE;
        end else if ((beats_q == target_q) && !tag_pending) begin
          // Closed burst whose last word could not be tagged.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d      = rd_en;
    inflight_last_d = issue_last;
  end

  // Output buffer update: apply any retag, then pop the head, then append the returning word.
  always_comb begin
    ent_dat_d[0] = ent_dat_q[0];
    ent_dat_d[1] = ent_dat_q[1];
    ent_last_d   = ent_last_q;
    occ_d        = occ_q;
    if (retag_ent0) ent_last_d[0] = 1'b1;
    if (retag_ent1) ent_last_d[1] = 1'b1;
    if (pop) begin
      ent_dat_d[0]  = ent_dat_d[1];
      ent_last_d[0] = ent_last_d[1];
      ent_last_d[1] = 1'b0;
      occ_d         = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) begin
        ent_dat_d[0]  = i_fifo_rd_data;
        ent_last_d[0] = push_last;
      end else begin
        ent_dat_d[1]  = i_fifo_rd_data;
        ent_last_d[1] = push_last;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  // FSM, counters and in-flight tracking registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      beats_q         <= '0;
      target_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      beats_q         <= beats_d;
      target_q        <= target_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // Output buffer registers; a reset discards any buffered words.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ent_dat_q[0] <= '0;
      ent_dat_q[1] <= '0;
      ent_last_q   <= '0;
      occ_q        <= '0;
    end else begin
      ent_dat_q[0] <= ent_dat_d[0];
      ent_dat_q[1] <= ent_dat_d[1];
      ent_last_q   <= ent_last_d;
      occ_q        <= occ_d;
    end
  end

  assign o_fifo_rd_en = rd_en;
  assign o_m_data     = ent_dat_q[0];
  assign o_m_valid    = (occ_q != 2'd0);
  assign o_m_last     = ent_last_q[0];
  assign o_busy       = (state_q == ST_BURST);

`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] word_cnt_q;
  logic [15:0] burst_cnt_q;

  // Free-running transfer counters; both wrap on overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (pop) word_cnt_q <= word_cnt_q + 32'd1;
      if (pop && ent_last_q[0]) burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign o_word_cnt  = word_cnt_q;
  assign o_burst_cnt = burst_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
`timescale 1ns/1ps
module tb_fifo_burst_reader;
  localparam int WIDTH      = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int BURST_LEN  = 4;
  localparam int TIMEOUT    = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       e_flag;
  logic [3:0] fcount;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic       busy;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] word_cnt;
  logic [15:0] burst_cnt;
`endif
  logic       wr_en;
  logic [7:0] wr_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .o_fifo_rd_en(rd_en),
    .i_fifo_rd_data(rd_data),
    .i_fifo_rd_valid(rd_valid),
    .i_fifo_e_flag(e_flag),
    .i_fifo_count(fcount),
    .o_m_data(m_data),
    .o_m_valid(m_valid),
    .o_m_last(m_last),
    .i_m_ready(m_ready),
`ifdef FIFO_BURST_READER_STATS_EN
    .o_word_cnt(word_cnt),
    .o_burst_cnt(burst_cnt),
`endif
    .o_busy(busy)
  );

  // Behavioural FIFO: registered read data one cycle after the request, shares rst.
  logic [7:0] fmem [16];
  logic [4:0] fcnt_q;
  logic [3:0] wp_q, rp_q;
  assign e_flag = (fcnt_q == 5'd0);
  assign fcount = fcnt_q[3:0];

  always @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0; wp_q <= '0; rp_q <= '0; rd_valid <= 1'b0; rd_data <= '0;
    end else begin
      rd_valid <= rd_en && (fcnt_q != 5'd0);
      if (rd_en && (fcnt_q != 5'd0)) begin
        rd_data <= fmem[rp_q];
        rp_q    <= rp_q + 4'd1;
      end
      if (wr_en) begin
        fmem[wp_q] <= wr_data;
        wp_q       <= wp_q + 4'd1;
      end
      fcnt_q <= fcnt_q + 5'(wr_en) - 5'(rd_en && (fcnt_q != 5'd0));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected stream: every word written, in order; last on every BURST_LEN-th word and the final one.
  typedef struct packed { logic [7:0] d; logic l; } word_t;
  word_t exp_q[$];

  task automatic expect_words(input logic [7:0] base, input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.d = base + 8'(i);
      w.l = (((i + 1) % BURST_LEN) == 0) || (i == n - 1);
      exp_q.push_back(w);
    end
  endtask

  int   issued = 0;
  int   popped = 0;
  int   stalls = 0;
  bit   held   = 1'b0;
  logic [7:0] held_d;
  logic       held_l;

  // Per-cycle compare against the expected stream, stall stability and read-occupancy bound.
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      held = 1'b0; issued = 0; popped = 0;
    end else begin
      if (held) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(held_d));
        check("stall_last", 32'(m_last), 32'(held_l));
      end
      if (rd_en) begin
        check("rd_when_empty", 32'(e_flag), 32'd0);
        check("outstanding_le2",
              32'((issued + 1 - popped - ((m_valid && m_ready) ? 1 : 0)) <= 2), 32'd1);
        issued++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_word", 32'(exp_q.size()), 32'd1);
        end else begin
          w = exp_q.pop_front();
          check("stream_data", 32'(m_data), 32'(w.d));
          check("stream_last", 32'(m_last), 32'(w.l));
        end
        popped++;
      end
      if (m_valid && !m_ready) stalls++;
      held   = m_valid && !m_ready;
      held_d = m_data;
      held_l = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (((exp_q.size() != 0) || m_valid || busy) && (n < 300)) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Captures 8 cycles from the first read request; bit i of each pattern is cycle i.
  task automatic probe_burst(input string tag, input logic [7:0] exp_rd, input logic [7:0] exp_vld,
                             input logic [7:0] exp_last, input logic [7:0] exp_busy,
                             input logic [7:0] first_data);
    logic [7:0] rp, vp, lp, bp, fd;
    bit got;
    int n = 0;
    while (!rd_en && (n < 80)) begin
      tick();
      n++;
    end
    check({tag, "_rd_en_seen"}, 32'(rd_en), 32'd1);
    rp = '0; vp = '0; lp = '0; bp = '0; fd = '0; got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rp[i] = rd_en; vp[i] = m_valid; lp[i] = m_last; bp[i] = busy;
      if (m_valid && !got) begin
        fd  = m_data;
        got = 1'b1;
      end
      tick();
    end
    check({tag, "_rd_en_cycles"}, 32'(rp), 32'(exp_rd));
    check({tag, "_valid_cycles"}, 32'(vp), 32'(exp_vld));
    check({tag, "_last_cycles"}, 32'(lp), 32'(exp_last));
    check({tag, "_busy_cycles"}, 32'(bp), 32'(exp_busy));
    check({tag, "_first_data"}, 32'(fd), 32'(first_data));
  endtask

  int gap;
  int p0;
  int n5;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; m_ready = 1'b0;

    // Reset: two cycles, all outputs low, then no reads while the FIFO is empty.
    tick(); tick();
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_rd_en", 32'(rd_en), 32'd0);
    end

    // Full burst: 4 back-to-back reads, words 1..4 on consecutive cycles, last on 4.
    m_ready = 1'b1;
    expect_words(8'h01, 4);
    write_words(8'h01, 4);
    probe_burst("full", 8'h0F, 8'h3C, 8'h20, 8'h3F, 8'h01);
    wait_drain("full");

    // Partial burst after the idle timeout: 32 quiet cycles counting the landing cycle.
    expect_words(8'h0A, 2);
    wr_en = 1'b1; wr_data = 8'h0A;
    tick();
    wr_data = 8'h0B;
    check("partial_not_empty", 32'(e_flag), 32'd0);
    gap = 0;
    while (!rd_en && (gap < 60)) begin
      gap++;
      tick();
      wr_en = 1'b0;
    end
    wr_en = 1'b0;
    check("partial_timeout_gap", 32'(gap), 32'd32);
    probe_burst("partial", 8'h03, 8'h0C, 8'h08, 8'h0F, 8'h0A);
    wait_drain("partial");

    // Backpressure: 8 words with ready toggling, lasts on words 4 and 8.
    stalls = 0;
    expect_words(8'h11, 8);
    for (int i = 0; i < 60; i++) begin
      wr_en   = (i < 8);
      wr_data = 8'h11 + 8'(i);
      m_ready = ((i % 2) == 0);
      tick();
    end
    wr_en = 1'b0; m_ready = 1'b1;
    wait_drain("backpressure");
    check("backpressure_stalls_seen", 32'(stalls > 0), 32'd1);

    // Reset mid-burst after two words left.
    p0 = popped;
    expect_words(8'h21, 4);
    write_words(8'h21, 4);
    n5 = 0;
    while (((popped - p0) < 2) && (n5 < 60)) begin
      tick();
      n5++;
    end
    check("midrst_two_streamed", 32'(popped - p0), 32'd2);
    rst = 1'b1; m_ready = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_fifo_count", 32'(fcount), 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_quiet", 32'({rd_en, m_valid}), 32'd0);
    end

    // Two more full bursts from a clean reset.
    for (int r = 0; r < 2; r++) begin
      expect_words(8'h31 + 8'(r * 4), 4);
      write_words(8'h31 + 8'(r * 4), 4);
      wait_drain("repeat");
    end
`ifdef FIFO_BURST_READER_STATS_EN
    check("stats_word_cnt", word_cnt, 32'd8);
    check("stats_burst_cnt", 32'(burst_cnt), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
